// File: rtl/fptd_razor_pkg.sv
// Shared definitions for the Razor timing-error controller of the fully
// parallel turbo decoder.
//   razor_sched_state_t : scheduler FSM state encoding
//   RAZOR_N_SEC, RAZOR_CODE_W, RAZOR_CODE_INIT : default configuration
package fptd_razor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    RECOVER = 2'd2,
    ADJUST  = 2'd3
  } razor_sched_state_t;

  localparam int RAZOR_N_SEC     = 8;
  localparam int RAZOR_CODE_W    = 4;
  localparam int RAZOR_CODE_INIT = 8;

endpackage

// File: rtl/razor_err_popcount.sv
// Combinational population count of the per-section Razor error flags.
//   vec   : N_SEC input flags
//   count : number of set flags, $clog2(N_SEC+1) bits
module razor_err_popcount #(
  parameter int N_SEC = 8
) (
  input  logic [N_SEC-1:0]             vec,
  output logic [$clog2(N_SEC+1)-1:0]   count
);

  localparam int CW = $clog2(N_SEC+1);

  always_comb begin
    count = '0;
    for (int i = 0; i < N_SEC; i++)
      count = count + CW'(vec[i]);
  end

endmodule

// File: rtl/razor_err_sched.sv
// Razor timing-error scheduler: collects per-section error flags, stalls the
// pipeline for a fixed recovery length per error, selects shadow-latch values
// for failing sections and adapts the clock-period code from per-window error
// counts.
// Optional build macro RAZOR_ERR_LOG_EN adds a sticky per-section error log.
// Ports:
//   Clock, nReset (async, active-low)
//   Start       : pulse, IDLE -> MONITOR
//   Stop        : level, return to IDLE (deferred while recovering)
//   Error_vec   : per-section Razor error flags
//   Stall       : pipeline freeze during recovery
//   Replay_sel  : per-section shadow-latch select
//   Period_code : clock period request (larger = slower)
//   Err_count   : saturating error count of the current window
//   Busy        : high outside IDLE
//   Err_log     : sticky failing-section log (zero when the log is not built)
import fptd_razor_pkg::*;

module razor_err_sched #(
  parameter int N_SEC       = RAZOR_N_SEC,
  parameter int CNT_W       = 8,
  parameter int WINDOW      = 64,
  parameter int UP_TH       = 4,
  parameter int DN_WINDOWS  = 4,
  parameter int RECOVER_CYC = 2,
  parameter int CODE_W      = RAZOR_CODE_W,
  parameter int CODE_INIT   = RAZOR_CODE_INIT
) (
  input  logic              Clock,
  input  logic              nReset,
  input  logic              Start,
  input  logic              Stop,
  input  logic [N_SEC-1:0]  Error_vec,
  output logic              Stall,
  output logic [N_SEC-1:0]  Replay_sel,
  output logic [CODE_W-1:0] Period_code,
  output logic [CNT_W-1:0]  Err_count,
  output logic              Busy,
  output logic [N_SEC-1:0]  Err_log
);

  localparam int PC_W = $clog2(N_SEC+1);
  localparam int WC_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int RC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;
  localparam int CL_W = $clog2(DN_WINDOWS+1);
  localparam logic [RC_W-1:0]   RC_INIT  = RC_W'(RECOVER_CYC-1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CODE_W-1:0] CODE_MAX = '1;

  razor_sched_state_t state, state_nx;
  logic [WC_W-1:0]  wcnt;
  logic [RC_W-1:0]  rcnt;
  logic [CL_W-1:0]  clean;
  logic             win_pend;   // window closed while an error took RECOVER
  logic [PC_W-1:0]  pop;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] cnt_acc;
  logic             err_any, win_last, rec_done;

  razor_err_popcount #(.N_SEC(N_SEC)) u_pop (.vec(Error_vec), .count(pop));

  assign err_any  = |Error_vec;
  assign win_last = (wcnt == WC_W'(WINDOW-1));
  assign rec_done = !err_any && (rcnt == '0);
  assign cnt_sum  = {1'b0, Err_count} + (CNT_W+1)'(pop);
  assign cnt_acc  = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (Start) state_nx = MONITOR;
      MONITOR: begin
        if (err_any)       state_nx = RECOVER;
        else if (Stop)     state_nx = IDLE;
        else if (win_last) state_nx = ADJUST;
      end
      RECOVER: begin
        // a completed window is always scored before honouring Stop
        if (rec_done)
          state_nx = win_pend ? ADJUST : (Stop ? IDLE : MONITOR);
      end
      ADJUST: begin
        if (err_any)   state_nx = RECOVER;
        else if (Stop) state_nx = IDLE;
        else           state_nx = MONITOR;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      wcnt        <= '0;
      rcnt        <= '0;
      clean       <= '0;
      win_pend    <= 1'b0;
      Stall       <= 1'b0;
      Replay_sel  <= '0;
      Period_code <= CODE_W'(CODE_INIT);
      Err_count   <= '0;
      Busy        <= 1'b0;
    end else begin
      state <= state_nx;
      Busy  <= (state_nx != IDLE);
      case (state)
        IDLE: if (Start) begin
          wcnt      <= '0;
          Err_count <= '0;
          win_pend  <= 1'b0;
        end
        MONITOR: begin
          Err_count <= cnt_acc;
          if (!win_last) wcnt <= wcnt + 1'b1;
          if (err_any) begin
            Replay_sel <= Error_vec;
            Stall      <= 1'b1;
            rcnt       <= RC_INIT;
            if (win_last) win_pend <= 1'b1;
          end
        end
        RECOVER: begin
          Err_count <= cnt_acc;
          if (err_any) begin
            Replay_sel <= Replay_sel | Error_vec;
            rcnt       <= RC_INIT;
          end else if (rcnt == '0) begin
            Stall      <= 1'b0;
            Replay_sel <= '0;
          end else begin
            rcnt <= rcnt - 1'b1;
          end
        end
        ADJUST: begin
          // this cycle's errors belong to the next window
          Err_count <= CNT_W'(pop);
          wcnt      <= '0;
          win_pend  <= 1'b0;
          if (Err_count >= CNT_W'(UP_TH)) begin
            if (Period_code != CODE_MAX) Period_code <= Period_code + 1'b1;
            clean <= '0;
          end else if (Err_count == '0) begin
            if (clean + 1'b1 == CL_W'(DN_WINDOWS)) begin
              if (Period_code != '0) Period_code <= Period_code - 1'b1;
              clean <= '0;
            end else begin
              clean <= clean + 1'b1;
            end
          end else begin
            clean <= '0;
          end
          if (err_any) begin
            Replay_sel <= Error_vec;
            Stall      <= 1'b1;
            rcnt       <= RC_INIT;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAZOR_ERR_LOG_EN
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset)
      Err_log <= '0;
    else if (state == IDLE) begin
      if (Start) Err_log <= '0;
    end else
      Err_log <= Err_log | Error_vec;
  end
`else
  assign Err_log = '0;
`endif

endmodule
